pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator; successor to the single-channel 16-bit PWM block.
- One shared period counter drives CHANNELS compare outputs.
- Edge-aligned or center-aligned counting.
- TOP, compare values and mode are double-buffered and take effect only at period boundaries, so there are no glitched periods.
- Sits on a simple register-write bus inside the timer/peripheral subsystem.

Parameters:
WIDTH, 16, counter/compare/TOP/data width in bits
CHANNELS, 4, number of PWM outputs (1..WIDTH)
ADDR_W, $clog2(CHANNELS+3), register address width (derived; not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
nrst  input  1  synchronous reset, active low
we  input  1  register write strobe, one write per cycle
addr  input  ADDR_W  register select
wdata  input  WIDTH  write data
rdata  output  WIDTH  combinational readback of addressed shadow/control register
cnt  output  WIDTH  current counter value
out  output  CHANNELS  PWM outputs
period_end  output  1  high during the final cycle of each period while enabled

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Register map:
  - 0 CTRL: bit0 EN, bit1 MODE (0 edge, 1 center); other bits read 0.
  - 1 TOP (shadow).
  - 2 POL (bits [CHANNELS-1:0]).
  - 3+k CMP[k] (shadow).
  - Out-of-range address: write ignored, read 0.
- Buffering:
  - EN and POL act on the next cycle after the write.
  - MODE, TOP and CMP[k] are written to shadow registers.
  - Shadows are copied to the active registers on the clock edge that ends a period.
  - While EN=0, active registers follow the shadows every cycle.
- A write in the same cycle as a period end stores wdata in the shadow, and the active register loads that new value (write wins).
- Edge mode:
  - cnt counts 0,1,..,TOP, then wraps to 0; period = TOP+1.
  - Last cycle of the period: cnt >= TOP. This also recovers if cnt > TOP.
- Center mode:
  - Up-count 0..TOP, then down-count TOP-1..1, then back to 0; period = 2*TOP.
  - Internal dir flag; last cycle: dir=down and cnt==1.
  - TOP=0 or TOP=1: cnt stays 0 or toggles 0/1 respectively; every cycle is a period end for TOP=0.
- Raw compare: raw[k] = (cnt < CMP_act[k]), unsigned WIDTH-bit compare.
  - CMP=0 → raw always 0.
  - CMP > TOP (edge) or CMP > TOP (center) → raw always 1.
- Output: out[k] = raw[k] XOR POL[k], registered-free (combinational from cnt, CMP_act, POL).
- EN=0 (idle):
  - cnt held at 0, dir=up, period_end=0.
  - out[k] = POL[k] (raw forced 0).
- EN 0→1: first counting cycle shows cnt=0 with freshly loaded active values.
- EN 1→0: cnt returns to 0 on the next edge; the current period is abandoned.
- MODE change takes effect at the period boundary; dir resets to up at every mode change.
- Reset (nrst=0 at a clock edge, any time including mid-period):
  - All of CTRL, POL, shadow and active TOP/CMP, cnt and dir are cleared.
  - out=0, period_end=0, rdata reflects cleared registers.
  - Writes in a reset cycle are ignored.
- Arithmetic: cnt never exceeds 2^WIDTH-1; TOP = all-ones is legal (edge period 2^WIDTH, no overflow wrap error).

Test Plan:
1. Reset: WIDTH=8, CHANNELS=4, run with random writes, then nrst=0 for 2 cycles → cnt=0, out=4'b0000, rdata=0 at every address, period_end=0.
2. Edge: TOP=9, CMP0=3, CMP1=0, CMP2=10, CMP3=9, EN=1, MODE=0 → cnt 0..9 repeating.
   - out0 high at cnt 0–2; out1 always 0; out2 always 1; out3 high 9 of 10 cycles.
   - period_end high exactly when cnt=9.
3. Center: TOP=4, CMP0=2, MODE=1, EN=1 → cnt sequence 0,1,2,3,4,3,2,1 repeating, period 8.
   - out0 high at cnt 0,1 and at the down-count cnt=1 (3 cycles).
   - period_end at the down-count cnt=1.
4. Double buffer: edge, TOP=9, CMP0=3; write CMP0=7 when cnt=4 → rest of current period unchanged; next period out0 high for cnt 0–6. Also write TOP=4 in the cnt=9 cycle → next period is 0..4.
5. Polarity/enable: POL=4'b0101 with EN=0 → out=4'b0101. Then set EN=1 with CMP0=3, TOP=9 → out0 low for cnt 0–2, high for 3–9. Clear EN → next cycle cnt=0, out=4'b0101.
6. Reset mid-operation: center mode, at cnt=3 going down, assert nrst=0 for 1 cycle → next cycle cnt=0, all registers 0. After release, no counting until EN is written.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with one shared edge/center-aligned period counter
// TOP, CMP and MODE are double-buffered and are copied to the active set only at period boundaries or while idle.
module pwm_multi #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS + 3)
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [WIDTH-1:0]    wdata,
   output logic [WIDTH-1:0]    rdata,
   output logic [WIDTH-1:0]    cnt,
   output logic [CHANNELS-1:0] out,
   output logic                period_end
);

   logic                en;
   logic                mode_sh;
   logic                mode_act;
   logic                dir;
   logic [WIDTH-1:0]    top_sh;
   logic [WIDTH-1:0]    top_act;
   logic [CHANNELS-1:0] pol;
   logic [WIDTH-1:0]    cmp_sh  [CHANNELS];
   logic [WIDTH-1:0]    cmp_act [CHANNELS];

   logic                en_nxt;
   logic                mode_sh_nxt;
   logic [WIDTH-1:0]    top_sh_nxt;
   logic [CHANNELS-1:0] pol_nxt;
   logic [WIDTH-1:0]    cmp_sh_nxt [CHANNELS];
   logic                last;
   logic                load;
   logic [CHANNELS-1:0] raw;
   int                  addr_i;

   assign addr_i = int'(addr);

   // Post-write register values; the active set loads these so a write in the boundary cycle wins.
   always_comb begin
      en_nxt      = en;
      mode_sh_nxt = mode_sh;
      top_sh_nxt  = top_sh;
      pol_nxt     = pol;
      for (int k = 0; k < CHANNELS; k++) cmp_sh_nxt[k] = cmp_sh[k];
      if (we) begin
         if (addr_i == 0) begin
            en_nxt      = wdata[0];
            mode_sh_nxt = wdata[1];
         end
         if (addr_i == 1) top_sh_nxt = wdata;
         if (addr_i == 2) pol_nxt = wdata[CHANNELS-1:0];
         for (int k = 0; k < CHANNELS; k++)
            if (addr_i == k + 3) cmp_sh_nxt[k] = wdata;
      end
   end

   // Center mode with TOP<=1 has no down-count phase, so the period ends on the up side.
   always_comb begin
      if (!mode_act)
         last = (cnt >= top_act);
      else if (dir)
         last = (cnt == WIDTH'(1));
      else
         last = (top_act <= WIDTH'(1)) && (cnt >= top_act);
   end

   assign period_end = en && last;
   assign load       = !en || last;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         en       <= 1'b0;
         mode_sh  <= 1'b0;
         mode_act <= 1'b0;
         dir      <= 1'b0;
         top_sh   <= '0;
         top_act  <= '0;
         pol      <= '0;
         cnt      <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            cmp_sh[k]  <= '0;
            cmp_act[k] <= '0;
         end
      end else begin
         en      <= en_nxt;
         mode_sh <= mode_sh_nxt;
         top_sh  <= top_sh_nxt;
         pol     <= pol_nxt;
         for (int k = 0; k < CHANNELS; k++) cmp_sh[k] <= cmp_sh_nxt[k];
         if (load) begin
            mode_act <= mode_sh_nxt;
            top_act  <= top_sh_nxt;
            for (int k = 0; k < CHANNELS; k++) cmp_act[k] <= cmp_sh_nxt[k];
         end
         if (!en || !en_nxt) begin
            cnt <= '0;
            dir <= 1'b0;
         end else if (!mode_act) begin
            cnt <= last ? '0 : cnt + WIDTH'(1);
            dir <= 1'b0;
         end else if (dir) begin
            if (cnt <= WIDTH'(1)) begin
               cnt <= '0;
               dir <= 1'b0;
            end else begin
               cnt <= cnt - WIDTH'(1);
            end
         end else if (cnt >= top_act) begin
            if (top_act <= WIDTH'(1)) begin
               cnt <= '0;
            end else begin
               cnt <= top_act - WIDTH'(1);
               dir <= 1'b1;
            end
         end else begin
            cnt <= cnt + WIDTH'(1);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) raw[k] = en && (cnt < cmp_act[k]);
   end

   assign out = raw ^ pol;

   always_comb begin
      rdata = '0;
      if (addr_i == 0) rdata[1:0] = {mode_sh, en};
      if (addr_i == 1) rdata = top_sh;
      if (addr_i == 2) rdata[CHANNELS-1:0] = pol;
      for (int k = 0; k < CHANNELS; k++)
         if (addr_i == k + 3) rdata = cmp_sh[k];
   end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - scoreboard bench for pwm_multi (WIDTH=8, CHANNELS=4)
module tb_pwm_multi;

   logic       clk;
   logic       nrst;
   logic       we;
   logic [2:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic [7:0] cnt;
   logic [3:0] out;
   logic       period_end;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int         tag;
      logic [7:0] c;
      logic [3:0] o;
      logic       pe;
      logic       chk;
      logic [7:0] rd;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   seq[8] = '{0, 1, 2, 3, 4, 3, 2, 1};

   pwm_multi #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk(clk), .nrst(nrst), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .cnt(cnt), .out(out), .period_end(period_end)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() > 0) begin
         cur = q.pop_front();
         compared++;
         if (cnt !== cur.c || out !== cur.o || period_end !== cur.pe ||
             (cur.chk && rdata !== cur.rd)) begin
            mismatched++;
            $display("FAIL vec%0d: got cnt=%0d out=%b pe=%b rdata=%0d, want cnt=%0d out=%b pe=%b rdata=%0d%s",
                     cur.tag, cnt, out, period_end, rdata, cur.c, cur.o, cur.pe, cur.rd,
                     cur.chk ? "" : " (rdata unchecked)");
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic w, input logic [2:0] a, input logic [7:0] d);
      we    = w;
      addr  = a;
      wdata = d;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      drv(1'b1, a, d);
      tick();
      drv(1'b0, 3'd0, 8'd0);
   endtask

   task automatic push(input int tag, input logic [7:0] c, input logic [3:0] o,
                       input logic pe, input logic chk, input logic [7:0] rd);
      exp_t e;
      e.tag = tag;
      e.c   = c;
      e.o   = o;
      e.pe  = pe;
      e.chk = chk;
      e.rd  = rd;
      q.push_back(e);
   endtask

   initial begin
      logic [7:0] c;
      logic       o0, o3, pe;
      int         top;
      int         cmp0;

      nrst = 1'b0;
      drv(1'b0, 3'd0, 8'd0);
      tick();
      tick();

      // Reset after random traffic; writes during reset must be ignored.
      nrst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drv(1'b1, 3'($urandom_range(0, 7)), 8'($urandom));
         tick();
      end
      nrst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drv(1'b1, 3'($urandom_range(0, 7)), 8'hFF);
         tick();
      end
      for (int a = 0; a < 8; a++) begin
         drv(1'b1, 3'(a), 8'hFF);
         push(100 + a, 8'd0, 4'b0000, 1'b0, 1'b1, 8'd0);
         tick();
      end
      nrst = 1'b1;
      for (int a = 0; a < 8; a++) begin
         drv(1'b0, 3'(a), 8'd0);
         push(110 + a, 8'd0, 4'b0000, 1'b0, 1'b1, 8'd0);
         tick();
      end

      // Edge mode, then shadowed CMP0 and boundary-cycle TOP writes.
      wr(3'd1, 8'd9);
      wr(3'd3, 8'd3);
      wr(3'd4, 8'd0);
      wr(3'd5, 8'd10);
      wr(3'd6, 8'd9);
      drv(1'b1, 3'd0, 8'd1);
      push(200, 8'd0, 4'b0000, 1'b0, 1'b0, 8'd0);
      tick();
      for (int i = 0; i < 50; i++) begin
         drv(1'b0, 3'd0, 8'd0);
         if (i == 24) drv(1'b1, 3'd3, 8'd7);
         if (i == 39) drv(1'b1, 3'd1, 8'd4);
         top  = (i < 40) ? 9 : 4;
         cmp0 = (i < 30) ? 3 : 7;
         c    = 8'((i < 40) ? (i % 10) : ((i - 40) % 5));
         o0   = (int'(c) < cmp0);
         o3   = (c < 8'd9);
         pe   = (int'(c) == top);
         push(300 + i, c, {o3, 1'b1, 1'b0, o0}, pe, 1'b0, 8'd0);
         tick();
      end

      // Polarity while idle, then enabled with inverted outputs.
      drv(1'b1, 3'd0, 8'd0);
      push(500, 8'd0, 4'b1101, 1'b0, 1'b0, 8'd0);
      tick();
      drv(1'b1, 3'd2, 8'd5);
      push(501, 8'd0, 4'b0000, 1'b0, 1'b0, 8'd0);
      tick();
      drv(1'b0, 3'd2, 8'd0);
      push(502, 8'd0, 4'b0101, 1'b0, 1'b1, 8'd5);
      tick();
      drv(1'b0, 3'd1, 8'd0);
      push(503, 8'd0, 4'b0101, 1'b0, 1'b1, 8'd4);
      tick();
      drv(1'b1, 3'd1, 8'd9);
      push(504, 8'd0, 4'b0101, 1'b0, 1'b0, 8'd0);
      tick();
      drv(1'b1, 3'd3, 8'd3);
      push(505, 8'd0, 4'b0101, 1'b0, 1'b0, 8'd0);
      tick();
      drv(1'b0, 3'd7, 8'd0);
      push(506, 8'd0, 4'b0101, 1'b0, 1'b1, 8'd0);
      tick();
      drv(1'b1, 3'd0, 8'd1);
      push(507, 8'd0, 4'b0101, 1'b0, 1'b0, 8'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drv(1'b0, 3'd0, 8'd0);
         c  = 8'(i);
         o0 = !(c < 8'd3);
         o3 = (c < 8'd9);
         push(510 + i, c, {o3, 1'b0, 1'b0, o0}, (c == 8'd9), 1'b1, 8'd1);
         tick();
      end
      drv(1'b1, 3'd0, 8'd0);
      push(520, 8'd0, 4'b1000, 1'b0, 1'b0, 8'd0);
      tick();
      drv(1'b0, 3'd0, 8'd0);
      push(521, 8'd0, 4'b0101, 1'b0, 1'b1, 8'd0);
      tick();
      push(522, 8'd0, 4'b0101, 1'b0, 1'b1, 8'd0);
      tick();

      // Center mode, then reset while counting down through cnt=3.
      wr(3'd2, 8'd0);
      wr(3'd1, 8'd4);
      wr(3'd3, 8'd2);
      wr(3'd0, 8'd3);
      for (int i = 0; i < 22; i++) begin
         drv(1'b0, 3'd0, 8'd0);
         if (i == 21) nrst = 1'b0;
         c  = 8'(seq[i % 8]);
         o0 = (c < 8'd2);
         push(600 + i, c, {1'b1, 1'b1, 1'b0, o0}, (i % 8 == 7), 1'b1, 8'd3);
         tick();
      end
      nrst = 1'b1;
      for (int a = 0; a < 8; a++) begin
         drv(1'b0, 3'(a), 8'd0);
         push(700 + a, 8'd0, 4'b0000, 1'b0, 1'b1, 8'd0);
         tick();
      end

      tick();
      tick();
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
